// File: rtl/alu_instruction_sequencer.sv
// alu_instruction_sequencer
// Buffers opaque ALU instruction words in a small FIFO and issues them one at
// a time. After a fixed ALU latency it captures the ALU outputs into a result
// register, which is handed downstream over a valid/ready handshake.
// Only one instruction is in flight at a time, so results leave in push order.
module alu_instruction_sequencer #(
  parameter int INSTR_WIDTH = 26,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_in_valid,
  input  logic [INSTR_WIDTH-1:0]        i_in_instruction,
  output logic                          o_in_ready,
  output logic [INSTR_WIDTH-1:0]        o_alu_instruction,
  input  logic [DATA_WIDTH-1:0]         i_alu_out,
  input  logic                          i_alu_overflow,
  input  logic                          i_alu_c_out,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  output logic                          o_res_overflow,
  output logic                          o_res_c_out,
  output logic                          o_sticky_overflow,
  input  logic                          i_clear_sticky,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  // Instruction storage (data only; pointers/count carry the reset state)
  logic [INSTR_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic [1:0]             r_state;
  logic [WW-1:0]          r_wait_cnt;
  logic [INSTR_WIDTH-1:0] r_alu_instruction;
  logic                   r_res_valid;
  logic [DATA_WIDTH-1:0]  r_res_data;
  logic                   r_res_overflow;
  logic                   r_res_c_out;
  logic                   r_sticky;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_handshake;
  logic w_capture;
  logic w_not_empty;

  // Ready depends on the registered count only, so a full queue never accepts
  assign w_in_ready  = (r_count < CW'(FIFO_DEPTH));
  assign w_push      = i_in_valid & w_in_ready;
  assign w_not_empty = (r_count != '0);
  assign w_handshake = r_res_valid & i_res_ready;
  // A new word is popped either from IDLE or on the edge a result is consumed
  assign w_pop       = w_not_empty &
                       ((r_state == S_IDLE) | ((r_state == S_RESULT) & w_handshake));
  assign w_capture   = (r_state == S_WAIT) & (r_wait_cnt == WW'(1));

  // Write accepted words into the queue storage
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_instruction;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop keeps count steady
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue / wait / result sequencing and result capture
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state           <= S_IDLE;
      r_wait_cnt        <= '0;
      r_alu_instruction <= '0;
      r_res_valid       <= 1'b0;
      r_res_data        <= '0;
      r_res_overflow    <= 1'b0;
      r_res_c_out       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_instruction <= r_mem[r_rd_ptr];
            r_wait_cnt        <= WW'(ALU_LATENCY);
            r_state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_capture) begin
            r_res_data     <= i_alu_out;
            r_res_overflow <= i_alu_overflow;
            r_res_c_out    <= i_alu_c_out;
            r_res_valid    <= 1'b1;
            r_state        <= S_RESULT;
          end else begin
            r_wait_cnt <= r_wait_cnt - WW'(1);
          end
        end
        S_RESULT: begin
          if (w_handshake) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_alu_instruction <= r_mem[r_rd_ptr];
              r_wait_cnt        <= WW'(ALU_LATENCY);
              r_state           <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a capture with overflow takes priority over a clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sticky <= 1'b0;
    end else if (w_capture & i_alu_overflow) begin
      r_sticky <= 1'b1;
    end else if (i_clear_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_in_ready        = w_in_ready;
  assign o_alu_instruction = r_alu_instruction;
  assign o_res_valid       = r_res_valid;
  assign o_res_data        = r_res_data;
  assign o_res_overflow    = r_res_overflow;
  assign o_res_c_out       = r_res_c_out;
  assign o_sticky_overflow = r_sticky;
  assign o_fifo_count      = r_count;
  assign o_busy            = (r_state != S_IDLE) | w_not_empty;

endmodule
